// File: rtl/cofi_blend_if.sv
// Control bundle between the GPU/video timing side and the blend controller.
// COFI_CTRL_STATS_EN adds the blend_frames status counter output.
interface cofi_blend_if;
  logic       ce_pixel;
  logic [1:0] cfg_mode;
  logic       cfg_reduced;
  logic       dither_frame;
  logic       hblank;
  logic       vblank;
  logic       force_blend;
  logic       diff_blend;
  logic       reduced;
  logic [1:0] auto_state;
  logic       blend_active;
`ifdef COFI_CTRL_STATS_EN
  logic [15:0] blend_frames;

  modport master (
    output ce_pixel, cfg_mode, cfg_reduced, dither_frame, hblank, vblank,
    input  force_blend, diff_blend, reduced, auto_state, blend_active, blend_frames
  );
  modport slave (
    input  ce_pixel, cfg_mode, cfg_reduced, dither_frame, hblank, vblank,
    output force_blend, diff_blend, reduced, auto_state, blend_active, blend_frames
  );
`else
  modport master (
    output ce_pixel, cfg_mode, cfg_reduced, dither_frame, hblank, vblank,
    input  force_blend, diff_blend, reduced, auto_state, blend_active
  );
  modport slave (
    input  ce_pixel, cfg_mode, cfg_reduced, dither_frame, hblank, vblank,
    output force_blend, diff_blend, reduced, auto_state, blend_active
  );
`endif
endinterface

// File: rtl/cofi_blend_ctrl.sv
// Frame-level sequencer for the dither-removal blender: config shadowing, auto-detect FSM
// and per-pixel gating. Optional COFI_CTRL_STATS_EN adds the blend_frames counter.
module cofi_blend_ctrl #(
  parameter int unsigned ON_FRAMES  = 2,
  parameter int unsigned OFF_FRAMES = 8,
  parameter int unsigned EDGE_PIX   = 1,
  parameter int unsigned PIX_W      = 10
) (
  input  logic         clk,
  input  logic         reset,
  cofi_blend_if.slave  bus
);

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StArmed = 2'd1,
    StOn    = 2'd2,
    StHold  = 2'd3
  } state_e;

  localparam logic [3:0]       OnCnt   = 4'(ON_FRAMES);
  localparam logic [3:0]       OffCnt  = 4'(OFF_FRAMES);
  localparam logic [PIX_W-1:0] EdgeCnt = PIX_W'(EDGE_PIX);

  state_e           state_q, state_d;
  logic [3:0]       hit_q, hit_d, miss_q, miss_d;
  logic             seen_q, seen_d, seen_now;
  logic             vblank_dly_q, vblank_dly_d;
  logic [1:0]       mode_q, mode_d;
  logic             sred_q, sred_d;
  logic             active_q, active_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             edge_ok;
  logic             force_q, force_d, diff_q, diff_d, red_q, red_d;
  logic             fb;

  // Frame boundary logic: a pulse landing on the boundary clk belongs to the closing frame.
  always_comb begin
    fb           = bus.ce_pixel && bus.vblank && !vblank_dly_q;
    seen_now     = seen_q | bus.dither_frame;
    seen_d       = fb ? 1'b0 : seen_now;
    vblank_dly_d = bus.ce_pixel ? bus.vblank : vblank_dly_q;
    state_d      = state_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    mode_d       = mode_q;
    sred_d       = sred_q;
    active_d     = active_q;
    if (fb) begin
      mode_d = bus.cfg_mode;
      sred_d = bus.cfg_reduced;
      if (bus.cfg_mode == 2'd3) begin
        if (seen_now) begin
          hit_d  = (hit_q == 4'hf) ? hit_q : hit_q + 4'd1;
          miss_d = 4'd0;
        end else begin
          miss_d = (miss_q == 4'hf) ? miss_q : miss_q + 4'd1;
          hit_d  = 4'd0;
        end
        unique case (state_q)
          StOff: begin
            if (seen_now) state_d = (ON_FRAMES == 1) ? StOn : StArmed;
          end
          StArmed: begin
            if (!seen_now)          state_d = StOff;
            else if (hit_d >= OnCnt) state_d = StOn;
          end
          StOn: begin
            if (!seen_now) state_d = (OFF_FRAMES == 1) ? StOff : StHold;
          end
          StHold: begin
            if (seen_now)             state_d = StOn;
            else if (miss_d >= OffCnt) state_d = StOff;
          end
          default: state_d = StOff;
        endcase
      end else begin
        hit_d   = 4'd0;
        miss_d  = 4'd0;
        state_d = StOff;
      end
      active_d = (bus.cfg_mode == 2'd1) || (bus.cfg_mode == 2'd2) ||
                 ((bus.cfg_mode == 2'd3) && ((state_d == StOn) || (state_d == StHold)));
    end
  end

  // Per-pixel gating; outputs lag hblank/vblank by one ce_pixel.
  always_comb begin
    edge_ok = (pix_q >= EdgeCnt);
    pix_d   = pix_q;
    force_d = force_q;
    diff_d  = diff_q;
    red_d   = red_q;
    if (bus.ce_pixel) begin
      pix_d   = bus.hblank ? '0 : ((&pix_q) ? pix_q : pix_q + 1'b1);
      force_d = active_q && (mode_q != 2'd2) && !bus.hblank && !bus.vblank && edge_ok;
      diff_d  = active_q && (mode_q == 2'd2) && !bus.hblank && !bus.vblank;
      red_d   = active_q && sred_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StOff;
      hit_q        <= 4'd0;
      miss_q       <= 4'd0;
      seen_q       <= 1'b0;
      vblank_dly_q <= 1'b0;
      mode_q       <= 2'd0;
      sred_q       <= 1'b0;
      active_q     <= 1'b0;
      pix_q        <= '0;
      force_q      <= 1'b0;
      diff_q       <= 1'b0;
      red_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      seen_q       <= seen_d;
      vblank_dly_q <= vblank_dly_d;
      mode_q       <= mode_d;
      sred_q       <= sred_d;
      active_q     <= active_d;
      pix_q        <= pix_d;
      force_q      <= force_d;
      diff_q       <= diff_d;
      red_q        <= red_d;
    end
  end

  assign bus.force_blend  = force_q;
  assign bus.diff_blend   = diff_q;
  assign bus.reduced      = red_q;
  assign bus.auto_state   = state_q;
  assign bus.blend_active = active_q;

`ifdef COFI_CTRL_STATS_EN
  logic [15:0] frames_q, frames_d;

  // Counts frames that were blended, i.e. the outgoing blend_active at each boundary.
  always_comb begin
    frames_d = frames_q;
    if (fb && active_q && (frames_q != 16'hffff)) frames_d = frames_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frames_q <= 16'd0;
    else       frames_q <= frames_d;
  end

  assign bus.blend_frames = frames_q;
`endif

endmodule

// File: tb/tb_cofi_blend_ctrl.sv
// Bench for cofi_blend_ctrl: frame-level vector table, hand corner sequences and a
// randomized run against a frame-rule reference model.
module tb_cofi_blend_ctrl;
  localparam int ON_FRAMES  = 2;
  localparam int OFF_FRAMES = 8;
  localparam int EDGE_PIX   = 1;
  localparam int PIX_W      = 10;
  localparam int H_ACT      = 8;
  localparam int LINE       = 11;
  localparam int V_ACT      = 4;
  localparam int V_TOT      = 6;
  localparam int FRAME      = LINE * V_TOT;
  localparam int FB_POS     = LINE * V_ACT;
  localparam int S_OFF = 0, S_ARMED = 1, S_ON = 2, S_HOLD = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cofi_blend_if bus ();

  cofi_blend_ctrl #(
    .ON_FRAMES (ON_FRAMES),
    .OFF_FRAMES(OFF_FRAMES),
    .EDGE_PIX  (EDGE_PIX),
    .PIX_W     (PIX_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_mode, m_state, m_hits, m_misses, m_col, m_frames;
  bit m_red, m_active, m_seen, m_vb_prev;
  bit e_force, e_diff, e_red;

  typedef struct {
    int         mode;
    bit         red;
    bit         dith;
    logic [1:0] exp_state;
    logic       exp_active;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_state = S_OFF; m_hits = 0; m_misses = 0; m_col = 0; m_frames = 0;
    m_red = 0; m_active = 0; m_seen = 0; m_vb_prev = 0;
    e_force = 0; e_diff = 0; e_red = 0;
  endtask

  function automatic int next_state(int s, bit hit, int hits, int misses);
    case (s)
      S_OFF:   return hit ? ((ON_FRAMES == 1) ? S_ON : S_ARMED) : S_OFF;
      S_ARMED: return !hit ? S_OFF : ((hits >= ON_FRAMES) ? S_ON : S_ARMED);
      S_ON:    return hit ? S_ON : ((OFF_FRAMES == 1) ? S_OFF : S_HOLD);
      default: return hit ? S_ON : ((misses >= OFF_FRAMES) ? S_OFF : S_HOLD);
    endcase
  endfunction

  task automatic close_frame(input bit seen);
    if (m_active && m_frames < 65535) m_frames++;
    m_mode = int'(bus.cfg_mode);
    m_red  = bus.cfg_reduced;
    if (m_mode == 3) begin
      if (seen) begin m_hits = (m_hits < 15) ? m_hits + 1 : 15; m_misses = 0; end
      else begin m_misses = (m_misses < 15) ? m_misses + 1 : 15; m_hits = 0; end
      m_state = next_state(m_state, seen, m_hits, m_misses);
    end else begin
      m_hits = 0; m_misses = 0; m_state = S_OFF;
    end
    m_active = (m_mode == 1) || (m_mode == 2) || (m_mode == 3 && m_state >= S_ON);
  endtask

  task automatic model_step(input bit ce, input bit hb, input bit vb, input bit df);
    if (!ce) begin
      m_seen |= df;
      return;
    end
    e_force = m_active && m_mode != 2 && !hb && !vb && (m_col >= EDGE_PIX);
    e_diff  = m_active && m_mode == 2 && !hb && !vb;
    e_red   = m_active && m_red;
    m_col   = hb ? 0 : ((m_col < (1 << PIX_W) - 1) ? m_col + 1 : m_col);
    if (vb && !m_vb_prev) begin
      close_frame(m_seen || df);
      m_seen = 0;
    end else begin
      m_seen |= df;
    end
    m_vb_prev = vb;
  endtask

  task automatic check_outputs(input string name);
    logic [5:0] act, exp;
    act = {bus.force_blend, bus.diff_blend, bus.reduced, bus.auto_state, bus.blend_active};
    exp = {e_force, e_diff, e_red, 2'(m_state), m_active};
    check(name, 32'(act), 32'(exp));
`ifdef COFI_CTRL_STATS_EN
    check({name, " frames"}, 32'(bus.blend_frames), 32'(m_frames));
`endif
  endtask

  task automatic tick(input bit ce, input bit hb, input bit vb, input bit df);
    bus.ce_pixel = ce; bus.hblank = hb; bus.vblank = vb; bus.dither_frame = df;
    @(posedge clk);
    model_step(ce, hb, vb, df);
    #1;
    check_outputs("outputs");
    bus.dither_frame = 1'b0;
  endtask

  task automatic run_pixels(input int from, input int to, input bit dith, input int dpos,
                            input bit rnd);
    bit hb, vb;
    for (int p = from; p <= to; p++) begin
      hb = (p % LINE) >= H_ACT;
      vb = p >= FB_POS;
      if (rnd) while ($urandom_range(3) == 0) tick(1'b0, hb, vb, $urandom_range(15) == 0);
      tick(1'b1, hb, vb, dith && (p == dpos));
    end
  endtask

  task automatic run_frame(input int mode, input bit red, input bit dith, input int dpos,
                           input int chg, input bit rnd);
    run_pixels(0, chg - 1, dith, dpos, rnd);
    bus.cfg_mode = 2'(mode); bus.cfg_reduced = red;
    run_pixels(chg, FRAME - 1, dith, dpos, rnd);
  endtask

  vec_t tbl[$];

  initial begin
    // State/active after each frame's closing boundary, worked out from the frame rules.
    tbl = '{
      '{1, 0, 0, 2'd0, 1'b1}, '{1, 0, 0, 2'd0, 1'b1}, '{2, 1, 0, 2'd0, 1'b1},
      '{0, 1, 1, 2'd0, 1'b0}, '{3, 0, 1, 2'd1, 1'b0}, '{3, 1, 1, 2'd2, 1'b1},
      '{3, 0, 0, 2'd3, 1'b1}, '{3, 0, 0, 2'd3, 1'b1}, '{3, 0, 0, 2'd3, 1'b1},
      '{3, 0, 1, 2'd2, 1'b1}, '{3, 0, 0, 2'd3, 1'b1}, '{3, 0, 0, 2'd3, 1'b1},
      '{3, 0, 0, 2'd3, 1'b1}, '{3, 0, 0, 2'd3, 1'b1}, '{3, 0, 0, 2'd3, 1'b1},
      '{3, 0, 0, 2'd3, 1'b1}, '{3, 0, 0, 2'd3, 1'b1}, '{3, 0, 0, 2'd0, 1'b0},
      '{3, 0, 1, 2'd1, 1'b0}, '{3, 0, 0, 2'd0, 1'b0}, '{1, 0, 1, 2'd0, 1'b1},
      '{3, 0, 1, 2'd1, 1'b0}, '{3, 0, 1, 2'd2, 1'b1}, '{2, 0, 1, 2'd0, 1'b1}
    };

    reset = 1'b1;
    bus.ce_pixel = 0; bus.cfg_mode = 0; bus.cfg_reduced = 0;
    bus.dither_frame = 0; bus.hblank = 0; bus.vblank = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'({bus.force_blend, bus.diff_blend, bus.reduced,
                                bus.auto_state, bus.blend_active}), 32'd0);
    reset = 1'b0;

    // Frame-level vector table
    foreach (tbl[i]) begin
      run_frame(tbl[i].mode, tbl[i].red, tbl[i].dith, 5, 0, 1'b0);
      check($sformatf("tbl[%0d] state", i), 32'(bus.auto_state), 32'(tbl[i].exp_state));
      check($sformatf("tbl[%0d] active", i), 32'(bus.blend_active), 32'(tbl[i].exp_active));
    end

    // Line-edge suppression in force mode
    run_frame(1, 0, 0, 0, 0, 1'b0);
    bus.cfg_mode = 2'd0;
    run_pixels(0, 0, 0, 0, 1'b0);
    check("edge pix0 force", 32'(bus.force_blend), 32'd0);
    run_pixels(1, 1, 0, 0, 1'b0);
    check("edge pix1 force", 32'(bus.force_blend), 32'd1);
    check("edge pix1 diff", 32'(bus.diff_blend), 32'd0);
    run_pixels(2, FRAME - 1, 0, 0, 1'b0);

    // Mid-frame 0 -> 2 change takes effect only at the next boundary
    run_pixels(0, 19, 0, 0, 1'b0);
    bus.cfg_mode = 2'd2;
    run_pixels(20, 21, 0, 0, 1'b0);
    check("midchg diff held", 32'(bus.diff_blend), 32'd0);
    run_pixels(22, FRAME - 1, 0, 0, 1'b0);
    run_pixels(0, 1, 0, 0, 1'b0);
    check("after fb diff", 32'(bus.diff_blend), 32'd1);
    check("after fb force", 32'(bus.force_blend), 32'd0);
    run_pixels(2, FRAME - 1, 0, 0, 1'b0);

    // Pulse on the boundary clk counts for the closing frame only
    run_frame(3, 0, 0, 0, 0, 1'b0);
    check("coinc pre state", 32'(bus.auto_state), S_OFF);
    run_frame(3, 0, 1, FB_POS, 0, 1'b0);
    check("coinc hit state", 32'(bus.auto_state), S_ARMED);
    run_frame(3, 0, 0, 0, 0, 1'b0);
    check("coinc cleared state", 32'(bus.auto_state), S_OFF);

    // Asynchronous reset mid-line while blending
    run_frame(3, 0, 1, 5, 0, 1'b0);
    run_frame(3, 0, 1, 5, 0, 1'b0);
    check("pre-reset state", 32'(bus.auto_state), S_ON);
    run_pixels(0, 13, 1, 5, 1'b0);
    check("pre-reset force", 32'(bus.force_blend), 32'd1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async reset force", 32'(bus.force_blend), 32'd0);
    check("async reset state", 32'(bus.auto_state), S_OFF);
    check("async reset active", 32'(bus.blend_active), 32'd0);
`ifdef COFI_CTRL_STATS_EN
    check("async reset frames", 32'(bus.blend_frames), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_frame(1, 1, 0, 0, 0, 1'b0);
    run_frame(1, 1, 0, 0, 0, 1'b0);

    // Randomized frames with ce gaps, stray pulses and mid-frame config changes
    for (int f = 0; f < 40; f++) begin
      int mode;
      mode = ($urandom_range(1) == 1) ? 3 : int'($urandom_range(3));
      run_frame(mode, 1'($urandom_range(1)), 1'($urandom_range(1)),
                int'($urandom_range(FRAME - 1)), int'($urandom_range(FRAME - 1)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cofi_blend_ctrl.md
Name: cofi_blend_ctrl

Overview:
Frame-level controller that sequences the dither-removal blender in the video output path. It latches user blend configuration only at frame boundaries and runs an auto-detect state machine fed by the GPU's per-frame "dithering used" flag. Per pixel it drives the blender's force_blend / diff_blend / reduced controls, gated off during blanking and at line edges. It sits between the GPU/video timing generator and the blender, on the same clk / ce_pixel domain.

Parameters:
ON_FRAMES, 2, consecutive dithered frames required to enter blending in auto mode (1..15)
OFF_FRAMES, 8, consecutive non-dithered frames required to leave blending in auto mode (1..15)
EDGE_PIX, 1, active pixels at the start of each line with force_blend suppressed (0..15)
PIX_W, 10, width of the active-pixel counter

Ports:
clk  in  1  pixel-domain clock
reset  in  1  asynchronous reset, active-high
ce_pixel  in  1  pixel clock enable; all state advances only when high, except reset
cfg_mode  in  2  0=off, 1=force, 2=diff, 3=auto
cfg_reduced  in  1  requested reduced blend strength
dither_frame  in  1  single-clk pulse from GPU: current frame used dithering (not ce-qualified)
hblank  in  1  horizontal blank, same timing as blender input
vblank  in  1  vertical blank, same timing as blender input
force_blend  out  1  to blender force_blend
diff_blend  out  1  to blender diff_blend
reduced  out  1  to blender reduced
auto_state  out  2  FSM state, for status/OSD
blend_active  out  1  blending enabled for the current frame

Behaviour:
- Reset, asynchronous active-high; all outputs 0, FSM=OFF, counters 0, shadow mode=0, dither_seen=0.
- Frame boundary (FB): ce_pixel && vblank && !vblank_d. vblank_d is updated on ce_pixel only.
- dither_seen is a sticky latch set by dither_frame on any clk. At FB it is evaluated, then cleared.
- If dither_frame and FB coincide, the pulse counts for the frame being closed; dither_seen starts the next frame at 0.
- At FB, shadow_mode and shadow_reduced load from cfg_mode and cfg_reduced. Between FBs, config changes have no effect.
- Counters, evaluated at FB with the new shadow_mode == 3:
  - If dither_seen: hit_cnt = sat(hit_cnt+1) and miss_cnt = 0.
  - Otherwise: miss_cnt = sat(miss_cnt+1) and hit_cnt = 0.
  - Both are 4-bit and saturate at 15.
- If the new shadow_mode != 3, the FSM is forced to OFF and both counters are cleared.
- FSM states (auto_state encoding): OFF=0, ARMED=1, ON=2, HOLD=3. Transitions occur only at FB, using the updated counts.
  - OFF: hit -> ARMED, or -> ON directly if ON_FRAMES==1.
  - ARMED: hit_cnt >= ON_FRAMES -> ON; miss -> OFF.
  - ON: miss -> HOLD, or -> OFF directly if OFF_FRAMES==1.
  - HOLD: hit -> ON; miss_cnt >= OFF_FRAMES -> OFF.
- blend_active is registered at FB:
  - mode 1 or 2: 1.
  - mode 3: 1 when the next state is ON or HOLD.
  - mode 0: 0.
- Line gating:
  - pix_cnt is cleared while hblank is high.
  - Otherwise it increments on each ce_pixel, saturating at all-ones.
  - edge_ok = (pix_cnt >= EDGE_PIX).
- Outputs are registered and update on ce_pixel with 1 ce_pixel latency from hblank/vblank:
  - force_blend = blend_active && shadow_mode != 2 && !hblank && !vblank && edge_ok
  - diff_blend = blend_active && shadow_mode == 2 && !hblank && !vblank
  - reduced = blend_active && shadow_reduced
- Reset mid-frame: everything returns to reset values immediately. The first FB after reset reloads the config.
- ce_pixel low: outputs, counters and FSM hold. Only dither_seen may change.

Optional Feature:
COFI_CTRL_STATS_EN: adds output port blend_frames [15:0], plus its counter.
- The counter increments at each FB where the outgoing blend_active was 1.
- It saturates at 0xFFFF and clears on reset.
- Without the macro, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then cfg_mode=1 held for 2 frames. Required: all outputs 0 before the first FB. After it, force_blend=1 on active pixels except the first EDGE_PIX=1 pixel of each line, and 0 during hblank/vblank. diff_blend=0.
- cfg_mode changed 0->2 mid-frame. Required: outputs unchanged until the next FB, then diff_blend=1 on active pixels and force_blend=0.
- Auto mode, dither_frame pulsed in frames 1 and 2 (ON_FRAMES=2). Required: auto_state goes 0->1 at FB1 and 1->2 at FB2, and blend_active rises at FB2.
- Auto mode in ON, then 8 frames with no pulse. Required: state=3 at the first FB and state=0 at the 8th FB. A pulse in frame 4 instead returns the state to 2 at FB4.
- dither_frame pulse coincident with the FB clk. Required: counted for the closing frame (hit_cnt increments), and the next frame starts with dither_seen=0.
- Async reset asserted mid-line while in ON with force_blend=1. Required: force_blend=0 and auto_state=0 immediately with no clock edge. Under COFI_CTRL_STATS_EN, blend_frames=0.
